harmonic_analyser: RTL

//  Parametrised successor to the fixed 8-harmonic THD stage. Sits between the FFT

---
 rtl/harmonic_analyser.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/harmonic_analyser.sv
// Per-frame harmonic capture over an FFT magnitude stream, with optional auto-peak fundamental,
// power-of-two frame averaging and a shared squarer producing THD numerator/denominator terms.
module harmonic_analyser #(
    parameter int unsigned FFT_LEN  = 64,
    parameter int unsigned MAG_W    = 24,
    parameter int unsigned NUM_HARM = 8,
    parameter int unsigned AVG_LOG2 = 0,
    localparam int unsigned BIN_W   = $clog2(FFT_LEN),
    localparam int unsigned SUM_W   = 2 * MAG_W + $clog2(NUM_HARM)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_sop,
    input  logic                      in_eop,
    input  logic [MAG_W-1:0]          in_mag,
    input  logic                      cfg_auto,
    input  logic [BIN_W-1:0]          cfg_fund_bin,
    output logic [NUM_HARM*MAG_W-1:0] harm_mag,
    output logic [BIN_W-1:0]          fund_bin_out,
    output logic [2*MAG_W-1:0]        fund_sq,
    output logic [SUM_W-1:0]          sumsq_harm,
    output logic                      result_valid,
    output logic                      frame_err
);

    localparam int unsigned ACC_W  = MAG_W + AVG_LOG2;
    localparam int unsigned HIDX_W = $clog2(NUM_HARM + 1);
    localparam int unsigned SQ_W   = $clog2(NUM_HARM);
    localparam int unsigned CNT_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

    localparam logic [BIN_W:0]    HalfBin   = (BIN_W + 1)'(FFT_LEN / 2);
    localparam logic [BIN_W-1:0]  LastBin   = BIN_W'(FFT_LEN - 1);
    localparam logic [HIDX_W-1:0] NumHarm   = HIDX_W'(NUM_HARM);
    localparam logic [SQ_W-1:0]   LastSq    = SQ_W'(NUM_HARM - 1);
    localparam logic [CNT_W-1:0]  LastFrame = CNT_W'((1 << AVG_LOG2) - 1);

    typedef enum logic [1:0] {StIdle, StCollect, StSquare, StDone} state_e;

    state_e                     state_q, state_d;
    logic [BIN_W-1:0]           bin_q, bin_d;
    logic [BIN_W-1:0]           fund_q, fund_d;
    logic [BIN_W:0]             target_q, target_d;
    logic [HIDX_W-1:0]          hidx_q, hidx_d;
    logic [MAG_W-1:0]           cap_q [NUM_HARM];
    logic [MAG_W-1:0]           cap_d [NUM_HARM];
    logic [MAG_W-1:0]           pk_val_q, pk_val_d;
    logic [BIN_W-1:0]           pk_bin_q, pk_bin_d;
    logic [BIN_W-1:0]           stored_pk_q, stored_pk_d;
    logic                       trained_q, trained_d;
    logic                       train_q, train_d;
    logic [ACC_W-1:0]           acc_q [NUM_HARM];
    logic [ACC_W-1:0]           acc_d [NUM_HARM];
    logic [CNT_W-1:0]           frames_q, frames_d;
    logic [MAG_W-1:0]           avg_q [NUM_HARM];
    logic [MAG_W-1:0]           avg_d [NUM_HARM];
    logic [BIN_W-1:0]           grp_fund_q, grp_fund_d;
    logic [SQ_W-1:0]            sq_idx_q, sq_idx_d;
    logic [2*MAG_W-1:0]         fsq_acc_q, fsq_acc_d;
    logic [SUM_W-1:0]           sum_acc_q, sum_acc_d;
    logic [NUM_HARM*MAG_W-1:0]  harm_mag_q, harm_mag_d;
    logic [BIN_W-1:0]           fund_bin_q, fund_bin_d;
    logic [2*MAG_W-1:0]         fund_sq_q, fund_sq_d;
    logic [SUM_W-1:0]           sumsq_q, sumsq_d;
    logic                       result_valid_q, result_valid_d;
    logic                       frame_err_q, frame_err_d;

    logic                       accept;
    logic [BIN_W-1:0]           f_sel;
    logic [ACC_W-1:0]           acc_sum [NUM_HARM];
    logic [MAG_W-1:0]           sq_in;
    logic [2*MAG_W-1:0]         sq_prod;

    assign in_ready = (state_q == StIdle) || (state_q == StCollect);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d        = state_q;
        bin_d          = bin_q;
        fund_d         = fund_q;
        target_d       = target_q;
        hidx_d         = hidx_q;
        cap_d          = cap_q;
        pk_val_d       = pk_val_q;
        pk_bin_d       = pk_bin_q;
        stored_pk_d    = stored_pk_q;
        trained_d      = trained_q;
        train_d        = train_q;
        acc_d          = acc_q;
        frames_d       = frames_q;
        avg_d          = avg_q;
        grp_fund_d     = grp_fund_q;
        sq_idx_d       = sq_idx_q;
        fsq_acc_d      = fsq_acc_q;
        sum_acc_d      = sum_acc_q;
        harm_mag_d     = harm_mag_q;
        fund_bin_d     = fund_bin_q;
        fund_sq_d      = fund_sq_q;
        sumsq_d        = sumsq_q;
        result_valid_d = 1'b0;
        frame_err_d    = 1'b0;
        f_sel          = cfg_auto ? stored_pk_q : cfg_fund_bin;
        sq_in          = '0;
        for (int k = 0; k < NUM_HARM; k++) begin
            acc_sum[k] = acc_q[k] + ACC_W'(cap_q[k]);
            if (sq_idx_q == SQ_W'(k)) sq_in = avg_q[k];
        end
        sq_prod = {{MAG_W{1'b0}}, sq_in} * {{MAG_W{1'b0}}, sq_in};

        if (accept && in_sop) begin
            // A sop inside a frame flags the old frame and then starts a fresh one on this beat.
            if (state_q == StCollect) frame_err_d = 1'b1;
            if (!cfg_auto) trained_d = 1'b0;
            if ((!cfg_auto && cfg_fund_bin == '0) || in_eop) begin
                frame_err_d = 1'b1;
                state_d     = StIdle;
            end else begin
                state_d  = StCollect;
                bin_d    = BIN_W'(1);
                fund_d   = f_sel;
                target_d = {1'b0, f_sel};
                hidx_d   = '0;
                pk_val_d = '0;
                pk_bin_d = BIN_W'(1);
                train_d  = cfg_auto && !trained_q;
                for (int k = 0; k < NUM_HARM; k++) cap_d[k] = '0;
            end
        end else if (accept && state_q == StCollect) begin
            bin_d = bin_q + BIN_W'(1);
            if (hidx_q < NumHarm && target_q < HalfBin && {1'b0, bin_q} == target_q) begin
                for (int k = 0; k < NUM_HARM; k++) begin
                    if (hidx_q == HIDX_W'(k)) cap_d[k] = in_mag;
                end
                hidx_d   = hidx_q + HIDX_W'(1);
                target_d = target_q + {1'b0, fund_q};
            end
            if ({1'b0, bin_q} < HalfBin && in_mag > pk_val_q) begin
                pk_val_d = in_mag;
                pk_bin_d = bin_q;
            end
            if (in_eop != (bin_q == LastBin)) begin
                frame_err_d = 1'b1;
                state_d     = StIdle;
            end else if (in_eop) begin
                state_d     = StIdle;
                stored_pk_d = pk_bin_q;
                if (train_q) begin
                    trained_d = 1'b1;
                end else if (frames_q == LastFrame) begin
                    for (int k = 0; k < NUM_HARM; k++) begin
                        avg_d[k] = MAG_W'(acc_sum[k] >> AVG_LOG2);
                        acc_d[k] = '0;
                    end
                    frames_d   = '0;
                    grp_fund_d = fund_q;
                    sq_idx_d   = '0;
                    fsq_acc_d  = '0;
                    sum_acc_d  = '0;
                    state_d    = StSquare;
                end else begin
                    acc_d    = acc_sum;
                    frames_d = frames_q + CNT_W'(1);
                end
            end
        end

        if (state_q == StSquare) begin
            if (sq_idx_q == '0) fsq_acc_d = sq_prod;
            else sum_acc_d = sum_acc_q + SUM_W'(sq_prod);
            if (sq_idx_q == LastSq) state_d = StDone;
            else sq_idx_d = sq_idx_q + SQ_W'(1);
        end

        if (state_q == StDone) begin
            for (int k = 0; k < NUM_HARM; k++) harm_mag_d[k*MAG_W +: MAG_W] = avg_q[k];
            fund_bin_d     = grp_fund_q;
            fund_sq_d      = fsq_acc_q;
            sumsq_d        = sum_acc_q;
            result_valid_d = 1'b1;
            state_d        = StIdle;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            bin_q          <= '0;
            fund_q         <= '0;
            target_q       <= '0;
            hidx_q         <= '0;
            pk_val_q       <= '0;
            pk_bin_q       <= '0;
            stored_pk_q    <= '0;
            trained_q      <= 1'b0;
            train_q        <= 1'b0;
            frames_q       <= '0;
            grp_fund_q     <= '0;
            sq_idx_q       <= '0;
            fsq_acc_q      <= '0;
            sum_acc_q      <= '0;
            harm_mag_q     <= '0;
            fund_bin_q     <= '0;
            fund_sq_q      <= '0;
            sumsq_q        <= '0;
            result_valid_q <= 1'b0;
            frame_err_q    <= 1'b0;
            for (int k = 0; k < NUM_HARM; k++) begin
                cap_q[k] <= '0;
                acc_q[k] <= '0;
                avg_q[k] <= '0;
            end
        end else begin
            state_q        <= state_d;
            bin_q          <= bin_d;
            fund_q         <= fund_d;
            target_q       <= target_d;
            hidx_q         <= hidx_d;
            pk_val_q       <= pk_val_d;
            pk_bin_q       <= pk_bin_d;
            stored_pk_q    <= stored_pk_d;
            trained_q      <= trained_d;
            train_q        <= train_d;
            frames_q       <= frames_d;
            grp_fund_q     <= grp_fund_d;
            sq_idx_q       <= sq_idx_d;
            fsq_acc_q      <= fsq_acc_d;
            sum_acc_q      <= sum_acc_d;
            harm_mag_q     <= harm_mag_d;
            fund_bin_q     <= fund_bin_d;
            fund_sq_q      <= fund_sq_d;
            sumsq_q        <= sumsq_d;
            result_valid_q <= result_valid_d;
            frame_err_q    <= frame_err_d;
            for (int k = 0; k < NUM_HARM; k++) begin
                cap_q[k] <= cap_d[k];
                acc_q[k] <= acc_d[k];
                avg_q[k] <= avg_d[k];
            end
        end
    end

    assign harm_mag     = harm_mag_q;
    assign fund_bin_out = fund_bin_q;
    assign fund_sq      = fund_sq_q;
    assign sumsq_harm   = sumsq_q;
    assign result_valid = result_valid_q;
    assign frame_err    = frame_err_q;

endmodule
